fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of one fifo instance. Each producer uses a valid/ready handshake; the arbiter grants one producer at a time for a burst of up to MAX_BURST beats, then rotates. It drives the fifo's wr_en/din directly and watches its full flag, so no write is ever issued into a full fifo.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the fifo write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Counter width that stays legal when n is 1 ($clog2 would give 0).
  function automatic int clamp_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req at or after start, wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NQ = (IW+1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= NQ) sum = sum - NQ;
      cand = sum[IW-1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one fifo write port among producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = clamp_w(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);

  arb_state_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic            last_beat;
  logic [IW-1:0]   next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Write path is combinational so a full flag blocks the write in the same cycle.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == ARB_GRANT) begin
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = owner_valid && !fifo_full && rst_;
    end
    if (fifo_wr_en) fifo_din = owner_data;
  end

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign next_ptr  = (owner == LAST_ID) ? '0 : owner + 1'b1;
  assign grant_vld = (state == ARB_GRANT);
  assign grant_id  = owner;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A stall (valid high, fifo full) neither counts nor releases.
          if (fifo_wr_en ? last_beat : !owner_valid) begin
            rr_ptr <= next_ptr;
            state  <= ARB_IDLE;
          end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter with a fifo model
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_din;
  logic               grant_vld;
  logic [1:0]         grant_id;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          occ   = 0;
  logic        pend  = 1'b0;
  logic        force_full = 1'b0;
  logic [NR-1:0] acc = '0;
  logic [7:0]  pq [NR][$];
  logic [7:0]  wq [$];
  logic [7:0]  rd;

  int         b_gv  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int         b_we  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int         b_id  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [7:0] b_din [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00, 8'h00};

  int         c_gv  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int         c_we  [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
  logic [7:0] c_din [9] = '{8'h00, 8'h20, 8'h21, 8'h00, 8'h00, 8'h00, 8'h22, 8'h23, 8'h00};

  int         d_gv  [8] = '{0, 1, 1, 0, 1, 1, 1, 0};
  int         d_we  [8] = '{0, 1, 0, 0, 1, 1, 0, 0};
  int         d_id  [8] = '{1, 2, 2, 2, 3, 3, 3, 3};
  logic [7:0] d_din [8] = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h40, 8'h41, 8'h00, 8'h00};

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present producer heads and the fifo flag, settle, then log what the next edge will write.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (pq[i].size() > 0);
      req_data[i*DW +: DW] = 8'h00;
      if (pq[i].size() > 0) req_data[i*DW +: DW] = pq[i][0];
    end
    fifo_full = force_full || (occ >= DEPTH);
    #1;
    acc  = rst_ ? (req_valid & req_ready) : '0;
    pend = (fifo_wr_en === 1'b1);
    if (pend) begin
      wq.push_back(fifo_din);
      check("no_write_when_full", {31'b0, fifo_full}, 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pend) occ++;
    for (int i = 0; i < NR; i++) if (acc[i]) void'(pq[i].pop_front());
  endtask

  task automatic cyc();
    step();
    drive();
  endtask

  task automatic chk_cyc(input string tag, input int gv, input int id, input int we, input logic [7:0] din);
    logic [3:0] rdy;
    rdy = '0;
    if (gv != 0 && !fifo_full) rdy[id] = 1'b1;
    check({tag, "_gv"},  {31'b0, grant_vld},  32'(gv));
    check({tag, "_id"},  {30'b0, grant_id},   32'(id));
    check({tag, "_rdy"}, {28'b0, req_ready},  {28'b0, rdy});
    check({tag, "_we"},  {31'b0, fifo_wr_en}, 32'(we));
    check({tag, "_din"}, {24'b0, fifo_din},   {24'b0, din});
  endtask

  task automatic read_back(input string tag, input logic [7:0] exp);
    rd = 8'hxx;
    if (wq.size() > 0) begin
      rd = wq.pop_front();
      occ--;
    end
    check(tag, {24'b0, rd}, {24'b0, exp});
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Reset with every producer valid, then full contention into a 16-deep fifo.
    rst_ = 1'b0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 5; j++) pq[i].push_back(8'(i * 16 + j));
    drive();
    cyc();
    cyc();
    check("rst_ready", {28'b0, req_ready}, 32'd0);
    check("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("rst_gvld",  {31'b0, grant_vld}, 32'd0);
    check("rst_gid",   {30'b0, grant_id},  32'd0);
    rst_ = 1'b1;
    drive();
    check("rel_idle_gvld", {31'b0, grant_vld}, 32'd0);
    cyc();
    chk_cyc("first_grant", 1, 0, 1, 8'h00);
    for (int c = 2; c <= 21; c++) cyc();
    check("cont_occ", 32'(occ), 32'd16);
    chk_cyc("cont_stall", 1, 0, 0, 8'h00);
    check("cont_wq_len", 32'(wq.size()), 32'd16);
    for (int k = 0; k < 16; k++) read_back("cont_rd", 8'((k / 4) * 16 + (k % 4)));

    // Single producer 1 streaming six beats: burst of four, bubble, two, release.
    step();
    for (int i = 0; i < NR; i++) pq[i].delete();
    rst_ = 1'b0;
    drive();
    step();
    wq.delete();
    occ = 0;
    for (int j = 0; j < 6; j++) pq[1].push_back(8'(8'h10 + j));
    rst_ = 1'b1;
    drive();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      chk_cyc($sformatf("split_k%0d", k), b_gv[k], b_id[k], b_we[k], b_din[k]);
    end
    for (int k = 0; k < 6; k++) read_back("split_rd", 8'(8'h10 + k));

    // Fifo full forced after beat 2 for three cycles.
    for (int j = 0; j < 4; j++) pq[1].push_back(8'(8'h20 + j));
    drive();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        step();
        force_full = (k >= 3 && k <= 5);
        drive();
      end
      chk_cyc($sformatf("stall_k%0d", k), c_gv[k], 1, c_we[k], c_din[k]);
    end

    // Producer 2 drops valid after one beat while producer 3 waits.
    pq[2].push_back(8'h30);
    pq[3].push_back(8'h40);
    pq[3].push_back(8'h41);
    drive();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk_cyc($sformatf("early_k%0d", k), d_gv[k], d_id[k], d_we[k], d_din[k]);
      if (k == 3) check("early_rr_ptr", {30'b0, dut.rr_ptr}, 32'd3);
    end

    // Reset pulled during beat 2 of producer 1.
    wq.delete();
    occ = 0;
    for (int j = 0; j < 4; j++) pq[1].push_back(8'(8'h50 + j));
    pq[2].push_back(8'h60);
    drive();
    check("mid_k0_gvld", {31'b0, grant_vld}, 32'd0);
    cyc();
    chk_cyc("mid_k1", 1, 1, 1, 8'h50);
    step();
    rst_ = 1'b0;
    drive();
    check("mid_rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("mid_rst_din",   {24'b0, fifo_din},   32'd0);
    step();
    rst_ = 1'b1;
    drive();
    check("mid_after_gvld", {31'b0, grant_vld},  32'd0);
    check("mid_after_rr",   {30'b0, dut.rr_ptr}, 32'd0);
    check("mid_wq_len",     32'(wq.size()),      32'd1);
    cyc();
    chk_cyc("mid_regrant", 1, 1, 1, 8'h51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
